// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the FIFO transmit sequencer.
// Optional abort support is controlled by the TX_SEQ_ABORT_EN macro in the top.
package tx_seq_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // A requested length of zero means "drain the whole FIFO".
    localparam logic [CNT_W-1:0] BURST_ALL = '0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] burst_target(input logic [CNT_W-1:0] len);
        return (len == BURST_ALL) ? CNT_W'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/fifo_tx_sequencer_start_edge_det.sv
// Registered rising-edge detector; the history register resets high so a
// level already asserted when reset releases is not seen as an edge.
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) din_q <= 1'b1;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/fifo_tx_sequencer.sv
// Drains the transmit FIFO into a valid/ready byte sink, one pop per byte.
// Define TX_SEQ_ABORT_EN to add the abort input and aborted status output.
module fifo_tx_sequencer
    import tx_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tx,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] fifo_count,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
`ifdef TX_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    state_t           state, state_nx;
    logic             start_edge;
    logic [CNT_W-1:0] target;
    logic [CNT_W:0]   sent_inc;
    logic             fifo_has;
    logic             more;
    logic             abort_req;

    start_edge_det u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (start_tx),
        .rise (start_edge)
    );

    assign fifo_has = (fifo_count != '0);
    assign sent_inc = {1'b0, sent_count} + 1'b1;
    assign more     = (sent_inc < {1'b0, target});

`ifdef TX_SEQ_ABORT_EN
    logic abort_pend;

    // An abort seen any time after the pop is remembered until the next
    // decision point (end of WAIT or completion of the SEND handshake).
    assign abort_req = abort_pend | abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            if (state == IDLE)
                abort_pend <= 1'b0;
            else if (abort && (state == READ || state == WAIT || state == SEND))
                abort_pend <= 1'b1;

            if (state == IDLE && start_edge)
                aborted <= 1'b0;
            else if (abort_req && (state == WAIT || (state == SEND && tx_ready)))
                aborted <= 1'b1;
        end
    end
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_edge)
                    state_nx = fifo_has ? READ : DONE;
            end
            READ: begin
                // Occupancy is re-checked so a pop can never underflow.
                if (fifo_has) begin
                    fifo_rd_en = 1'b1;
                    state_nx   = WAIT;
                end else begin
                    state_nx = DONE;
                end
            end
            WAIT: begin
                state_nx = abort_req ? DONE : SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready)
                    state_nx = (more && fifo_has && !abort_req) ? READ : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            sent_count <= '0;
            tx_data    <= '0;
        end else begin
            state <= state_nx;

            if (state == IDLE && start_edge) begin
                target     <= burst_target(burst_len);
                sent_count <= '0;
            end

            if (state == WAIT && !abort_req)
                tx_data <= fifo_rd_data;

            if (state == SEND && tx_ready && sent_count != CNT_W'(DEPTH))
                sent_count <= sent_count + 1'b1;
        end
    end

endmodule

// File: doc/fifo_tx_sequencer.md
# fifo_tx_sequencer

Controller that drains the 16 x 8-bit transmit FIFO into a downstream byte sink. A rising edge on `start_tx` launches a burst: the block pops bytes through the FIFO read port one at a time and presents each on a valid/ready interface. It stops when the requested byte count is sent or the FIFO empties, then pulses `done`. It sits between the FIFO and the serializer and owns the FIFO read side exclusively.

## Interface
- `WIDTH`, 8, data byte width
- `DEPTH`, 16, FIFO depth; `CNT_W` = $clog2(DEPTH)+1 = 5
- `clk` input 1: single clock, all logic on posedge
- `rst` input 1: synchronous, active-high reset
- `start_tx` input 1: level; rising edge requests a burst
- `burst_len` input CNT_W: bytes requested, latched on the start edge; 0 = drain all
- `fifo_count` input CNT_W: current FIFO occupancy (0..DEPTH)
- `fifo_rd_data` input WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`
- `fifo_rd_en` output 1: one-cycle pop strobe
- `tx_ready` input 1: sink accepts the byte
- `tx_valid` output 1: `tx_data` is valid
- `tx_data` output WIDTH: byte to sink
- `busy` output 1: burst in progress
- `done` output 1: one-cycle pulse at burst end
- `sent_count` output CNT_W: bytes transferred in the current or last burst

## Operation
- Start edge detection: `start_q` registers `start_tx`; edge = `start_tx & ~start_q`. Edges while `busy` are dropped, not queued.
- The FSM has five states:
  - IDLE: on edge, latch target = (`burst_len`==0) ? DEPTH : `burst_len`, clear `sent_count`. Go to READ if `fifo_count`!=0, else go to DONE.
  - READ: `fifo_rd_en`=1 for exactly this cycle, then go to WAIT.
  - WAIT: capture `fifo_rd_data` into `tx_data`, then go to SEND.
  - SEND: `tx_valid`=1. On `tx_valid & tx_ready`, increment `sent_count`. Then go to READ if `sent_count+1` < target and `fifo_count`!=0; otherwise go to DONE. If `tx_ready` is low, stay in SEND.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `tx_data` is held stable and `tx_valid` is never withdrawn until the handshake completes.
- `fifo_rd_en` is never asserted when `fifo_count`==0. There is no underflow.
- `sent_count` saturates at DEPTH. It holds its value after DONE until the next start edge.
- `busy`=1 in READ, WAIT, SEND and DONE.

## Timing
- Reset values: `fifo_rd_en`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, `sent_count`=0, state=IDLE, `start_q`=1. A `start_tx` held high through reset does not fire.
- Start edge sampled at posedge N gives READ (`fifo_rd_en`=1) in cycle N+1, WAIT in N+2, and `tx_valid`=1 in N+3.
- Throughput with `tx_ready` tied high is 1 byte per 3 cycles.
- `fifo_count` sampled in SEND already reflects the pop issued in READ.
- An empty FIFO at the start edge gives `done` in cycle N+1 with `sent_count`=0.
- Reset mid-burst takes effect at the next posedge regardless of state:
  - All outputs return to their reset values.
  - A byte held in `tx_data` is lost.
  - No `done` pulse is generated.

## Configuration
- `TX_SEQ_ABORT_EN` defined: adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort` sampled in READ or WAIT: go to DONE after WAIT. The popped byte is discarded and not counted.
  - `abort` sampled in SEND: the current handshake completes, then go to DONE.
  - `aborted` is set on DONE entry caused by abort and cleared on the next start edge.
- `TX_SEQ_ABORT_EN` undefined: no `abort` or `aborted` ports. A burst always runs to target or empty.

## Structure
- `tx_seq_pkg` holds:
  - the state enum (IDLE, READ, WAIT, SEND, DONE)
  - WIDTH, DEPTH and CNT_W constants
  - the `burst_len`==0 drain-all encoding
- Sub-module `start_edge_det` is a registered rising-edge detector with reset value 1. It is reusable by the FIFO-side logic.
- The FSM and counters live in the top module.

## Test plan
- FIFO holds 5 bytes 0xA0..0xA4, `burst_len`=3, `tx_ready`=1 -> `tx_data` sequence A0, A1, A2; `done` at 3rd transfer+1; `sent_count`=3; `fifo_count` ends at 2.
- FIFO holds 4 bytes, `burst_len`=0 -> 4 transfers, `done`, `sent_count`=4; `fifo_rd_en` never high at `fifo_count`=0.
- `tx_ready` low for 7 cycles on the 2nd byte -> `tx_valid` and `tx_data` stable for all 7 cycles; no extra `fifo_rd_en`.
- FIFO empty, start edge -> `done` in N+1, `sent_count`=0, no `fifo_rd_en`. A second start edge during a 16-byte burst is ignored (exactly 16 transfers).
- `rst` asserted while in SEND -> next cycle all outputs 0 and state IDLE. `start_tx` held high across reset, with no new edge -> no burst.
- `TX_SEQ_ABORT_EN`: `abort` in WAIT of byte 2 -> `sent_count`=1, `aborted`=1, `done` pulse, byte 2 never presented.
